// File: rtl/mul_border_sched_if.sv
// Port bundle for the unary multiplier border-cell sequencer: operand request
// channel, result channel, abort/busy control and the datapath-facing signals.
// The master side is whatever surrounds the sequencer (requester, result
// consumer and the multiplier datapath); the slave side is the sequencer.
interface mul_border_sched_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = WIDTH + 1
);
  // Operand request channel
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data_i;
  logic [WIDTH-1:0]        in_data_w;
  logic [LEN_W-1:0]        cfg_len;
  logic                    abort;

  // Datapath control and product stream
  logic                    mul_rst_n;
  logic [WIDTH-1:0]        mul_data_i;
  logic [WIDTH-1:0]        mul_data_w;
  logic                    mul_o_bit;

  // Result channel
  logic                    out_valid;
  logic                    out_ready;
  logic [LEN_W-1:0]        out_ones;
  logic signed [LEN_W:0]   out_acc;

  logic                    busy;

  modport master (
    output in_valid, in_data_i, in_data_w, cfg_len, abort, mul_o_bit, out_ready,
    input  in_ready, mul_rst_n, mul_data_i, mul_data_w, out_valid, out_ones,
           out_acc, busy
  );

  modport slave (
    input  in_valid, in_data_i, in_data_w, cfg_len, abort, mul_o_bit, out_ready,
    output in_ready, mul_rst_n, mul_data_i, mul_data_w, out_valid, out_ones,
           out_acc, busy
  );
endinterface

// File: rtl/mul_border_sched.sv
// Sequencer for one bipolar unary multiplier border cell. Latches an operand
// pair, clears the datapath Sobol generators for one cycle, runs the cell for
// the programmed bitstream length while counting product ones, then presents
// the ones count and the signed bipolar result (2*ones - len) to the consumer.
module mul_border_sched #(
  parameter int WIDTH = 8,
  parameter int LEN_W = WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  mul_border_sched_if.slave  bus
);

  // Full Sobol period; a zero or oversized length request maps onto this.
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(1) << WIDTH;

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t                state_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cyc_q;
  logic [LEN_W-1:0]      ones_q;
  logic [LEN_W-1:0]      ones_nxt;
  logic                  last_sample;

  // Zero means a full period; anything longer than a period is clamped to it.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    if ((len == '0) || (len > FULL_LEN)) return FULL_LEN;
    return len;
  endfunction

  // Bipolar decode 2*ones - len. Computed modulo 2^(LEN_W+1); the true result
  // lies in [-2^WIDTH, +2^WIDTH], so the wrapped value is exact.
  function automatic logic signed [LEN_W:0] bipolar_acc(
    input logic [LEN_W-1:0] ones,
    input logic [LEN_W-1:0] len
  );
    logic [LEN_W:0] diff;
    diff = {ones, 1'b0} - {1'b0, len};
    return $signed(diff);
  endfunction

  assign ones_nxt    = ones_q + LEN_W'(bus.mul_o_bit);
  assign last_sample = (cyc_q == (len_q - LEN_W'(1)));

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);

  // Control FSM with registered datapath drive and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bus.mul_rst_n  <= 1'b0;
      bus.mul_data_i <= '0;
      bus.mul_data_w <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_ones   <= '0;
      bus.out_acc    <= '0;
      len_q          <= '0;
      cyc_q          <= '0;
      ones_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bus.mul_rst_n <= 1'b0;
          // Accept wins over a coincident abort: abort is not looked at here.
          if (bus.in_valid) begin
            bus.mul_data_i <= bus.in_data_i;
            bus.mul_data_w <= bus.in_data_w;
            len_q          <= norm_len(bus.cfg_len);
            state_q        <= CLR;
          end
        end

        CLR: begin
          cyc_q  <= '0;
          ones_q <= '0;
          if (bus.abort) begin
            bus.mul_rst_n <= 1'b0;
            state_q       <= IDLE;
          end else begin
            // Release the Sobol clear so the first RUN cycle samples index 0.
            bus.mul_rst_n <= 1'b1;
            state_q       <= RUN;
          end
        end

        RUN: begin
          if (bus.abort) begin
            bus.mul_rst_n <= 1'b0;
            cyc_q         <= '0;
            ones_q        <= '0;
            state_q       <= IDLE;
          end else begin
            ones_q <= ones_nxt;
            cyc_q  <= cyc_q + LEN_W'(1);
            if (last_sample) begin
              // Freeze the datapath and publish the result from the same edge.
              bus.mul_rst_n <= 1'b0;
              bus.out_ones  <= ones_nxt;
              bus.out_acc   <= bipolar_acc(ones_nxt, len_q);
              bus.out_valid <= 1'b1;
              state_q       <= DONE;
            end
          end
        end

        DONE: begin
          bus.mul_rst_n <= 1'b0;
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state_q       <= IDLE;
          end
        end

        default: begin
          bus.mul_rst_n <= 1'b0;
          bus.out_valid <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_border_sched.md
Name: mul_border_sched

Overview:
- Sequencer for one bipolar unary multiplier border cell.
- Accepts an operand pair (input activation, weight) plus a bitstream length over a valid/ready handshake, and holds the operands stable on the datapath.
- Pulses the datapath's active-low Sobol clear so every multiply starts from sequence index 0, then runs the cell for exactly the programmed number of cycles.
- Counts the cell's output ones and returns both the ones count and the signed bipolar result over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand width; the Sobol period is 2^WIDTH.
- LEN_W, WIDTH+1, width of the length and count fields; must hold the value 2^WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- in_data_i  in  WIDTH  input activation operand.
- in_data_w  in  WIDTH  weight operand.
- cfg_len  in  LEN_W  bitstream length; 0 means 2^WIDTH; values above 2^WIDTH saturate to 2^WIDTH.
- abort  in  1  synchronous cancel.
- mul_rst_n  out  1  active-low clear to the datapath Sobol generators.
- mul_data_i  out  WIDTH  registered activation to the datapath.
- mul_data_w  out  WIDTH  registered weight to the datapath.
- mul_o_bit  in  1  datapath product bit, combinational in the current cycle.
- out_valid  out  1  result available.
- out_ready  in  1  result consumer ready.
- out_ones  out  LEN_W  count of ones in the product stream.
- out_acc  out  LEN_W+1  signed result: 2*ones - len.
- busy  out  1  high in CLR, RUN or DONE.

Behaviour:
Reset (rst high, asynchronous):
- State = IDLE; mul_rst_n=0, out_valid=0, busy=0.
- mul_data_i, mul_data_w, out_ones, out_acc, internal length and cycle counters all = 0.
- in_ready=1 from the first clock after rst deasserts.

State machine (IDLE, CLR, RUN, DONE), all outputs registered except in_ready and busy, which decode state:
- IDLE: mul_rst_n=0.
  - On in_valid & in_ready: latch in_data_i/in_data_w into mul_data_i/mul_data_w; latch the normalised cfg_len into len_q; go to CLR.
- CLR (exactly 1 cycle): mul_rst_n=0; clear the ones and cycle counters; go to RUN.
- RUN: mul_rst_n=1.
  - Every cycle: ones += mul_o_bit; cyc += 1.
  - The cycle in which cyc == len_q-1 is the last sample; next state = DONE.
  - At that edge, register out_ones = final ones and out_acc = 2*ones - len_q (signed, LEN_W+1 bits, no overflow possible).
  - out_valid=1 from that edge.
- DONE: mul_rst_n=0 (freezes the datapath); out_valid=1 with out_ones/out_acc held stable.
  - On out_ready: out_valid=0, go to IDLE.
  - out_ready asserted in the same cycle out_valid first rises completes the transfer in that cycle.

Latency and handshake rules:
- Accept edge at cycle T → CLR at T+1 → RUN for cycles T+2 … T+1+len → out_valid high at T+2+len.
- At most one job in flight; in_ready=0 in CLR, RUN and DONE.
- mul_data_i and mul_data_w change only on an accept edge.

Abort:
- In CLR or RUN: go to IDLE next edge; no out_valid; mul_rst_n=0; counters cleared.
- In IDLE or DONE: ignored.
- abort coincident with an accept in IDLE: the accept wins.

Boundary conditions:
- len=1: RUN lasts 1 cycle.
- len=2^WIDTH: cyc reaches 2^WIDTH-1 without wrap; ones may reach 2^WIDTH, which fits in LEN_W bits.
- rst mid-RUN: immediate return to IDLE per the reset values above.
- mul_o_bit is ignored outside RUN.

Test Plan:
1. Reset, then in_data_i=0x80, in_data_w=0x40, cfg_len=16, mul_o_bit tied 0 → mul_rst_n low exactly 1 cycle (CLR), 16 RUN cycles, out_valid at T+18, out_ones=0, out_acc=-16, mul_data_i/mul_data_w = 0x80/0x40 throughout.
2. cfg_len=0, mul_o_bit tied 1 → 256 RUN cycles, out_ones=256, out_acc=+256, no counter wrap.
3. cfg_len=8, mul_o_bit alternating 1,0 from the first RUN cycle → out_ones=4, out_acc=0; then cfg_len=1 with mul_o_bit=1 → out_ones=1, out_acc=+1 after a single RUN cycle.
4. out_ready held low 10 cycles after out_valid → out_valid, out_ones and out_acc stable and in_ready=0 throughout; a new in_valid is not accepted until the cycle after out_ready is asserted.
5. abort asserted on RUN cycle 5 of a len=32 job → IDLE next cycle, no out_valid pulse, mul_rst_n=0, busy=0; a following len=4 job with mul_o_bit=1 returns out_ones=4, out_acc=+4.
6. rst pulsed asynchronously mid-RUN (between clock edges) → all outputs immediately at their reset values; a later job completes normally.
